pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, flow-controlled pipeline stage register; the next-generation replacement for the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a generic control vector and data vector, and adds valid/ready handshaking with a two-entry skid buffer, so back-pressure never creates a combinational ready path. It also adds a synchronous flush that turns in-flight instructions into bubbles. Control bits are always forced to zero on a bubble, so downstream write enables never fire on invalid slots.

## Interface
- CTRL_W, 3: control-bit width; bits are cleared on reset, flush and bubble (e.g. memtoreg/regwrite/memwrite).
- DATA_W, 69: payload width, not qualified by valid (e.g. result 32 + store data 32 + rd 5).
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- flush_i  in  1  synchronous flush; discards all held entries.
- valid_i  in  1  upstream entry valid.
- ready_o  out  1  stage can accept; registered.
- ctrl_i  in  CTRL_W  upstream control bits.
- data_i  in  DATA_W  upstream payload.
- valid_o  out  1  downstream entry valid.
- ready_i  in  1  downstream accepts.
- ctrl_o  out  CTRL_W  control bits; 0 whenever valid_o=0.
- data_o  out  DATA_W  payload.

## Operation
- Transfer definitions:
  - in_fire = valid_i & ready_o.
  - out_fire = valid_o & ready_i.
- Storage: main slot (drives outputs) and skid slot.
- State machine, one-hot or 2-bit:
  - EMPTY (nothing held).
  - BUSY (main valid).
  - FULL (main and skid valid).
- EMPTY: in_fire -> BUSY; main <= input.
- BUSY:
  - in_fire & out_fire -> BUSY; main <= input.
  - in_fire & !out_fire -> FULL; skid <= input.
  - !in_fire & out_fire -> EMPTY.
  - Otherwise hold.
- FULL: out_fire -> BUSY; main <= skid. in_fire cannot occur because ready_o=0.
- Output and ready values:
  - ready_o = registered (next_state != FULL).
  - valid_o = (state != EMPTY).
  - ctrl_o = main.ctrl & {CTRL_W{valid_o}}.
- Flush has priority over every transition:
  - Next state is EMPTY; both ctrl slots are cleared; ready_o goes to 1.
  - An in_fire or out_fire in the flush cycle still counts as a completed handshake for the other side.
  - The accepted input is dropped.
- Reset values: state EMPTY, valid_o 0, ctrl_o 0, ready_o 1, both ctrl slots 0. data_o depends on configuration.
- Reset asserted mid-operation clears state immediately, asynchronously. Held entries are lost.

## Timing
- Latency: 1 cycle from in_fire to valid_o with that entry.
- Throughput: 1 entry/cycle while ready_i=1.
- ready_o deasserts the cycle after the second entry is captured while ready_i=0. There is no combinational path from ready_i to ready_o.
- data_o and ctrl_o are stable while valid_o=1 and ready_i=0.
- Entries leave strictly in arrival order; there is no reordering or duplication.
- Flush sampled in cycle N: valid_o=0 and ready_o=1 from cycle N+1.

## Configuration
- PIPE_REG_DATA_RST_EN defined: the data slots are reset to 0 and cleared on flush, so data_o resets to 0.
- PIPE_REG_DATA_RST_EN undefined:
  - Data slots have no reset or flush clear, for lower area.
  - data_o is undefined until the first load.
  - data_o is meaningful only when valid_o=1.
- Control-bit clearing is unconditional in both builds.

## Structure
- Shared package pipe_reg_pkg:
  - typedef pipe_state_e {EMPTY, BUSY, FULL}.
  - Per-stage width constants, e.g. EXMEM_CTRL_W=3, EXMEM_DATA_W=69, IDEX_CTRL_W, etc.
- Sub-module pipe_reg_slot: one ctrl+data register with load and clear, instantiated for main and skid.
  - Load enable and clear inputs.
  - Owns the PIPE_REG_DATA_RST_EN reset/clear logic.

## Test plan
- Reset release, no input -> valid_o=0, ctrl_o=0, ready_o=1; data_o=0 when PIPE_REG_DATA_RST_EN is defined.
- Streaming with ready_i=1, entries ctrl=3'b011 and data=69'h1, 69'h2, 69'h3 on consecutive cycles -> same values on valid_o/data_o one cycle later, no gaps.
- Back-pressure:
  - Stimulus: ready_i=0, offer entries A=1, B=2, C=3.
  - Required: A held on outputs, B captured in skid, ready_o=0 from the cycle after B, C not accepted.
  - Then ready_i=1: output A, B, C in order with no loss.
- Flush while FULL:
  - Stimulus: flush_i=1 for one cycle.
  - Required: next cycle valid_o=0, ctrl_o=0, ready_o=1; entry offered in the flush cycle is not emitted.
- Bubble masking: valid_i=1 with ctrl_i=3'b111 for one cycle, then valid_i=0 with ctrl_i=3'b111 -> ctrl_o is 0 whenever valid_o=0.
- Asynchronous reset in BUSY:
  - Stimulus: rst_n_i low mid-cycle.
  - Required: valid_o=0 and ctrl_o=0 immediately, before the next clock edge; ready_o=1.

Source files
------------

// File: rtl/pipe_reg_pkg.sv
// Shared types and per-stage width constants for the flow-controlled pipeline stage registers.
package pipe_reg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam int IFID_CTRL_W  = 1;
    localparam int IFID_DATA_W  = 64;   // pc 32 + instr 32
    localparam int IDEX_CTRL_W  = 9;
    localparam int IDEX_DATA_W  = 111;  // rs1 32 + rs2 32 + imm 32 + rd/rs1/rs2 15
    localparam int EXMEM_CTRL_W = 3;
    localparam int EXMEM_DATA_W = 69;   // result 32 + store data 32 + rd 5
    localparam int MEMWB_CTRL_W = 2;
    localparam int MEMWB_DATA_W = 69;   // mem data 32 + alu result 32 + rd 5

endpackage

// File: rtl/pipe_reg_slot.sv
// One ctrl+data holding register with load and clear.
// PIPE_REG_DATA_RST_EN: when defined, the data register is also reset and flush-cleared.
module pipe_reg_slot #(
    parameter int CTRL_W = 3,
    parameter int DATA_W = 69
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    // Control bits must never survive a flush: downstream write enables key off them.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_q <= '0;
        end else if (clear_i) begin
            ctrl_q <= '0;
        end else if (load_i) begin
            ctrl_q <= ctrl_i;
        end
    end

`ifdef PIPE_REG_DATA_RST_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q <= '0;
        end else if (clear_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
        end
    end
`else
    // NOTE: the wide payload has no reset or clear; valid_o qualifies it, so the flops stay plain.
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            data_q <= data_i;
        end
    end
`endif

    assign ctrl_o = ctrl_q;
    assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with a two-entry skid buffer and synchronous flush.
// PIPE_REG_DATA_RST_EN: when defined, payload slots reset to 0 and clear on flush.
module pipe_stage_reg
    import pipe_reg_pkg::*;
#(
    parameter int CTRL_W = EXMEM_CTRL_W,
    parameter int DATA_W = EXMEM_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    pipe_state_e       state_q, state_d;
    logic              ready_q;
    logic              in_fire, out_fire;
    logic              main_load, skid_load;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
    logic [DATA_W-1:0] main_data, skid_data, main_data_d;

    assign valid_o  = (state_q != EMPTY);
    assign ready_o  = ready_q;
    assign in_fire  = valid_i & ready_q;
    assign out_fire = valid_o & ready_i;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d   = BUSY;
                    main_load = 1'b1;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end else if (in_fire) begin
                    state_d   = FULL;
                    skid_load = 1'b1;
                end else if (out_fire) begin
                    state_d   = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d   = BUSY;
                    main_load = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush_i) begin
            state_d   = EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    // Main refills from the skid when draining FULL, otherwise straight from upstream.
    assign main_ctrl_d = (state_q == FULL) ? skid_ctrl : ctrl_i;
    assign main_data_d = (state_q == FULL) ? skid_data : data_i;

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != FULL);
        end
    end

    pipe_reg_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (main_load),
        .clear_i (flush_i),
        .ctrl_i  (main_ctrl_d),
        .data_i  (main_data_d),
        .ctrl_o  (main_ctrl),
        .data_o  (main_data)
    );

    pipe_reg_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (skid_load),
        .clear_i (flush_i),
        .ctrl_i  (ctrl_i),
        .data_i  (data_i),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
    );

    assign ctrl_o = main_ctrl & {CTRL_W{valid_o}};
    assign data_o = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a two-deep FIFO reference model.
module tb_pipe_stage_reg;

    localparam int CW = 3;
    localparam int DW = 69;

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n_i;
    logic          flush_i;
    logic          valid_i;
    logic          ready_o;
    logic [CW-1:0] ctrl_i;
    logic [DW-1:0] data_i;
    logic          valid_o;
    logic          ready_i;
    logic [CW-1:0] ctrl_o;
    logic [DW-1:0] data_o;

    int   n_pass  = 0;
    int   n_total = 0;
    ent_t mq[$];
    bit   m_ready = 1'b1;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .ctrl_i  (ctrl_i),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .ctrl_o  (ctrl_o),
        .data_o  (data_o)
    );

    always #5 clk = ~clk;

    function automatic bit exp_valid();
        return mq.size() > 0;
    endfunction

    function automatic logic [CW-1:0] exp_ctrl();
        return (mq.size() > 0) ? mq[0].ctrl : '0;
    endfunction

    function automatic logic [DW-1:0] exp_data();
        return (mq.size() > 0) ? mq[0].data : '0;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    // Advance one clock edge and apply the same edge to the reference FIFO.
    task automatic clock_cycle();
        bit in_f, out_f;
        @(posedge clk);
        if (rst_n_i) begin
            in_f  = valid_i && m_ready;
            out_f = (mq.size() > 0) && ready_i;
            if (flush_i) begin
                mq.delete();
            end else begin
                if (out_f) void'(mq.pop_front());
                if (in_f) mq.push_back('{ctrl_i, data_i});
            end
            m_ready = flush_i || (mq.size() < 2);
        end
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        ctrl_i = '0; data_i = '0;
        model_reset();
        repeat (3) clock_cycle();
        rst_n_i = 1'b1;
        clock_cycle();
        n_total++; if (valid_o !== 1'b0) $display("FAIL reset_valid got %b exp 0", valid_o); else n_pass++;
        n_total++; if (ctrl_o !== '0) $display("FAIL reset_ctrl got %b exp 000", ctrl_o); else n_pass++;
        n_total++; if (ready_o !== 1'b1) $display("FAIL reset_ready got %b exp 1", ready_o); else n_pass++;
`ifdef PIPE_REG_DATA_RST_EN
        n_total++; if (data_o !== '0) $display("FAIL reset_data got %h exp 0", data_o); else n_pass++;
`endif
    endtask

    task automatic test_stream();
        ready_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            valid_i = 1'b1; ctrl_i = 3'b011; data_i = DW'(k);
            clock_cycle();
            n_total++; if (valid_o !== 1'b1) $display("FAIL stream_valid[%0d] got %b exp 1", k, valid_o); else n_pass++;
            n_total++; if (data_o !== DW'(k)) $display("FAIL stream_data[%0d] got %h exp %h", k, data_o, DW'(k)); else n_pass++;
            n_total++; if (ctrl_o !== 3'b011) $display("FAIL stream_ctrl[%0d] got %b exp 011", k, ctrl_o); else n_pass++;
            n_total++; if (ready_o !== 1'b1) $display("FAIL stream_ready[%0d] got %b exp 1", k, ready_o); else n_pass++;
        end
        valid_i = 1'b0;
        clock_cycle();
        n_total++; if (valid_o !== 1'b0) $display("FAIL stream_drain got %b exp 0", valid_o); else n_pass++;
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] got[$];
        bit            acc;
        ready_i = 1'b0;
        valid_i = 1'b1; ctrl_i = 3'b001; data_i = DW'(1);
        clock_cycle();
        n_total++; if (data_o !== DW'(1) || valid_o !== 1'b1) $display("FAIL bp_hold_a got v=%b d=%h exp v=1 d=1", valid_o, data_o); else n_pass++;
        n_total++; if (ready_o !== 1'b1) $display("FAIL bp_ready_after_a got %b exp 1", ready_o); else n_pass++;
        ctrl_i = 3'b010; data_i = DW'(2);
        clock_cycle();
        n_total++; if (ready_o !== 1'b0) $display("FAIL bp_ready_after_b got %b exp 0", ready_o); else n_pass++;
        ctrl_i = 3'b100; data_i = DW'(3);
        repeat (3) begin
            clock_cycle();
            n_total++; if (data_o !== DW'(1) || ctrl_o !== 3'b001) $display("FAIL bp_stable got c=%b d=%h exp c=001 d=1", ctrl_o, data_o); else n_pass++;
            n_total++; if (ready_o !== 1'b0) $display("FAIL bp_ready_full got %b exp 0", ready_o); else n_pass++;
        end
        ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (valid_o && ready_i) got.push_back(data_o);
            acc = valid_i && m_ready;
            clock_cycle();
            if (acc) valid_i = 1'b0;
            n_total++; if (valid_o !== exp_valid()) $display("FAIL bp_drain_valid got %b exp %b", valid_o, exp_valid()); else n_pass++;
        end
        n_total++; if (got.size() !== 3) $display("FAIL bp_count got %0d exp 3", got.size()); else n_pass++;
        for (int i = 0; i < got.size() && i < 3; i++) begin
            n_total++; if (got[i] !== DW'(i + 1)) $display("FAIL bp_order[%0d] got %h exp %h", i, got[i], DW'(i + 1)); else n_pass++;
        end
    endtask

    task automatic test_flush();
        ready_i = 1'b0; valid_i = 1'b1;
        ctrl_i = 3'b111; data_i = DW'(16'hE1);
        clock_cycle();
        data_i = DW'(16'hE2);
        clock_cycle();
        flush_i = 1'b1; data_i = DW'(16'hDD);
        clock_cycle();
        flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        n_total++; if (valid_o !== 1'b0) $display("FAIL flush_full_valid got %b exp 0", valid_o); else n_pass++;
        n_total++; if (ctrl_o !== '0) $display("FAIL flush_full_ctrl got %b exp 000", ctrl_o); else n_pass++;
        n_total++; if (ready_o !== 1'b1) $display("FAIL flush_full_ready got %b exp 1", ready_o); else n_pass++;
        // Flush in BUSY while an input handshakes: that input must be dropped.
        valid_i = 1'b1; ctrl_i = 3'b011; data_i = DW'(16'hA5);
        clock_cycle();
        flush_i = 1'b1; data_i = DW'(16'h5A); ready_i = 1'b0;
        clock_cycle();
        flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        repeat (3) begin
            n_total++; if (valid_o !== 1'b0) $display("FAIL flush_busy_valid got %b exp 0", valid_o); else n_pass++;
            n_total++; if (ready_o !== 1'b1) $display("FAIL flush_busy_ready got %b exp 1", ready_o); else n_pass++;
            clock_cycle();
        end
    endtask

    task automatic test_bubble();
        ready_i = 1'b1;
        valid_i = 1'b1; ctrl_i = 3'b111; data_i = rand_data();
        clock_cycle();
        n_total++; if (ctrl_o !== 3'b111) $display("FAIL bubble_live_ctrl got %b exp 111", ctrl_o); else n_pass++;
        valid_i = 1'b0;
        repeat (3) begin
            clock_cycle();
            n_total++; if (valid_o !== 1'b0) $display("FAIL bubble_valid got %b exp 0", valid_o); else n_pass++;
            n_total++; if (ctrl_o !== '0) $display("FAIL bubble_ctrl got %b exp 000", ctrl_o); else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            valid_i = ($urandom_range(3, 0) != 0);
            ready_i = ($urandom_range(2, 0) != 0);
            flush_i = ($urandom_range(15, 0) == 0);
            ctrl_i  = CW'($urandom_range(7, 0));
            data_i  = rand_data();
            clock_cycle();
            n_total++; if (valid_o !== exp_valid()) $display("FAIL rand_valid[%0d] got %b exp %b", c, valid_o, exp_valid()); else n_pass++;
            n_total++; if (ready_o !== m_ready) $display("FAIL rand_ready[%0d] got %b exp %b", c, ready_o, m_ready); else n_pass++;
            n_total++; if (ctrl_o !== exp_ctrl()) $display("FAIL rand_ctrl[%0d] got %b exp %b", c, ctrl_o, exp_ctrl()); else n_pass++;
            if (exp_valid()) begin
                n_total++; if (data_o !== exp_data()) $display("FAIL rand_data[%0d] got %h exp %h", c, data_o, exp_data()); else n_pass++;
            end
        end
        flush_i = 1'b0; valid_i = 1'b0;
    endtask

    task automatic test_async_reset();
        ready_i = 1'b0; valid_i = 1'b1; ctrl_i = 3'b110; data_i = rand_data();
        clock_cycle();
        valid_i = 1'b0;
        n_total++; if (valid_o !== 1'b1) $display("FAIL areset_busy got %b exp 1", valid_o); else n_pass++;
        #2 rst_n_i = 1'b0;
        model_reset();
        #1;
        n_total++; if (valid_o !== 1'b0) $display("FAIL areset_valid got %b exp 0", valid_o); else n_pass++;
        n_total++; if (ctrl_o !== '0) $display("FAIL areset_ctrl got %b exp 000", ctrl_o); else n_pass++;
        n_total++; if (ready_o !== 1'b1) $display("FAIL areset_ready got %b exp 1", ready_o); else n_pass++;
        clock_cycle();
        rst_n_i = 1'b1;
        clock_cycle();
        n_total++; if (valid_o !== 1'b0) $display("FAIL areset_release got %b exp 0", valid_o); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_bubble();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
